// File: rtl/uc_tile_pkg.sv
// Shared tile definitions: responder FSM states,
// csr bit positions and data_reg_c field offsets.
package uc_tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int CSR_FLASH_READY_BIT = 4;
    localparam int CSR_BOOT_BIT        = 8;

    localparam int C_PC_LSB   = 17;
    localparam int C_WE_BIT   = 16;
    localparam int C_WD_LSB   = 8;
    localparam int C_ADDR_LSB = 0;

endpackage

// File: rtl/uc_mem_responder_if.sv
// Tile <-> memory responder bundle: register buses,
// status words and program download handshake.
interface uc_mem_responder_if #(
    parameter int FLASH_AW = 12
);
    logic [31:0]       data_reg_c;
    logic [15:0]       csr_out;
    logic [31:0]       data_reg_a;
    logic [31:0]       data_reg_b;
    logic [15:0]       csr_in;
    logic              load_start;
    logic              prog_valid;
    logic              prog_ready;
    logic [15:0]       prog_data;
    logic              prog_last;
    logic              loaded;
    logic [FLASH_AW:0] prog_count;

    modport slave (
        input  data_reg_c, csr_out,
        input  load_start, prog_valid,
        input  prog_data, prog_last,
        output data_reg_a, data_reg_b, csr_in,
        output prog_ready, loaded, prog_count
    );

    modport master (
        output data_reg_c, csr_out,
        output load_start, prog_valid,
        output prog_data, prog_last,
        input  data_reg_a, data_reg_b, csr_in,
        input  prog_ready, loaded, prog_count
    );

endinterface

// File: rtl/uc_sync_ram.sv
// Single-write, registered-read RAM with write-first
// bypass; array is never reset, only the read register.
module uc_sync_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (we && (waddr == raddr))
            rdata <= wdata;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/uc_mem_responder.sv
// Program/data memory responder for a uc tile:
// downloads program words, then serves fetches and sram.
module uc_mem_responder
    import uc_tile_pkg::*;
#(
    parameter int FLASH_AW = 12,
    parameter int SRAM_AW  = 8
) (
    input logic          clk,
    input logic          arst_n,
    uc_mem_responder_if.slave bus
);

    localparam logic [FLASH_AW-1:0] PTR_MAX = '1;

    state_e state, state_nx;

    logic [FLASH_AW-1:0] ptr, ptr_nx;
    logic [FLASH_AW:0]   cnt, cnt_nx;
    logic [FLASH_AW-1:0] pc, prev_pc;
    logic [SRAM_AW-1:0]  sm_addr;
    logic                run_d1;
    logic                accept;
    logic                sm_we;
    logic                flash_ready;
    logic [15:0]         pm_q;
    logic [7:0]          sm_q;
    logic                unused_bits;

    assign pc      = bus.data_reg_c[C_PC_LSB +: FLASH_AW];
    assign sm_addr = bus.data_reg_c[C_ADDR_LSB +: SRAM_AW];

    // a simultaneous load_start wins; the word is dropped
    assign accept = (state == ST_LOAD) &&
                    bus.prog_valid && !bus.load_start;

    assign sm_we = (state == ST_RUN) &&
                   bus.data_reg_c[C_WE_BIT];

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        if (bus.load_start) begin
            state_nx = ST_LOAD;
            ptr_nx   = '0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (accept) begin
                        ptr_nx = ptr + 1'b1;
                        cnt_nx = cnt + 1'b1;
                        if (bus.prog_last || ptr == PTR_MAX)
                            state_nx = ST_RUN;
                    end
                end
                ST_IDLE, ST_RUN: ;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            prev_pc <= '0;
            run_d1  <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            prev_pc <= pc;
            run_d1  <= (state == ST_RUN);
        end
    end

    // data is valid once the current pc was already
    // presented on the previous edge of a RUN cycle
    assign flash_ready = (state == ST_RUN) && run_d1 &&
                         (pc == prev_pc);

    uc_sync_ram #(
        .DW(16),
        .AW(FLASH_AW)
    ) u_pmem (
        .clk  (clk),
        .rst_n(arst_n),
        .we   (accept),
        .waddr(ptr),
        .wdata(bus.prog_data),
        .raddr(pc),
        .rdata(pm_q)
    );

    uc_sync_ram #(
        .DW(8),
        .AW(SRAM_AW)
    ) u_smem (
        .clk  (clk),
        .rst_n(arst_n),
        .we   (sm_we),
        .waddr(sm_addr),
        .wdata(bus.data_reg_c[C_WD_LSB +: 8]),
        .raddr(sm_addr),
        .rdata(sm_q)
    );

    assign bus.prog_ready = (state == ST_LOAD);
    assign bus.loaded     = (state == ST_RUN);
    assign bus.prog_count = cnt;
    assign bus.csr_in     =
        16'(flash_ready) << CSR_FLASH_READY_BIT;
    assign bus.data_reg_a = {24'b0, sm_q};
    assign bus.data_reg_b = (state == ST_RUN) ?
                            {16'b0, pm_q} : 32'b0;

    assign unused_bits = ^{bus.csr_out, bus.data_reg_c};

endmodule

// File: tb/tb_uc_mem_responder.sv
// Directed vector bench for uc_mem_responder
// (FLASH_AW=12 main instance plus a FLASH_AW=2 instance).
module tb_uc_mem_responder;

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    always #5 clk = ~clk;

    uc_mem_responder_if #(.FLASH_AW(12)) bus ();
    uc_mem_responder_if #(.FLASH_AW(2))  bus2 ();

    uc_mem_responder #(
        .FLASH_AW(12),
        .SRAM_AW (8)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus.slave)
    );

    uc_mem_responder #(
        .FLASH_AW(2),
        .SRAM_AW (8)
    ) dut2 (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus2.slave)
    );

    typedef struct {
        bit          rst;
        bit          ld;
        bit          pv;
        logic [15:0] pd;
        bit          pl;
        logic [31:0] c;
        bit          rdy;
        bit          lo;
        int          cnt;
        bit          fr;
        logic [15:0] b;
        bit          ca;
        logic [7:0]  a;
    } vec_t;

    vec_t tv[$];
    int npass = 0;
    int ntot  = 0;

    function automatic logic [31:0] cw(
        int pc, bit we = 0, int wd = 0, int ad = 0);
        return (32'(pc) << 17) | (32'(we) << 16) |
               32'((wd & 8'hFF) << 8) | 32'(ad & 8'hFF);
    endfunction

    function automatic vec_t mk(
        bit rst, bit ld, bit pv, int pd, bit pl,
        logic [31:0] c, bit rdy, bit lo, int cnt,
        bit fr, int b, bit ca = 0, int a = 0);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pv = pv;
        v.pd = 16'(pd); v.pl = pl; v.c = c;
        v.rdy = rdy; v.lo = lo; v.cnt = cnt;
        v.fr = fr; v.b = 16'(b); v.ca = ca; v.a = 8'(a);
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    initial begin
        bus.data_reg_c = '0; bus.csr_out = 16'h0100;
        bus.load_start = 0; bus.prog_valid = 0;
        bus.prog_data = '0; bus.prog_last = 0;
        bus2.data_reg_c = '0; bus2.csr_out = '0;
        bus2.load_start = 0; bus2.prog_valid = 0;
        bus2.prog_data = '0; bus2.prog_last = 0;

        //        rst ld pv pd      pl c  rdy lo cnt fr b
        tv.push_back(mk(0,1,0,0,0,cw(0), 0,0,0,0,0));
        tv.push_back(mk(0,0,1,'h1111,0,cw(0), 1,0,0,0,0));
        tv.push_back(mk(0,0,1,'h2222,0,cw(0), 1,0,1,0,0));
        tv.push_back(mk(0,0,1,'h3333,1,cw(0), 1,0,2,0,0));
        tv.push_back(mk(0,0,0,0,0,cw(0), 0,1,3,0,'h1111));
        tv.push_back(mk(0,0,0,0,0,cw(0), 0,1,3,1,'h1111));
        tv.push_back(mk(0,0,0,0,0,cw(1), 0,1,3,0,'h1111));
        tv.push_back(mk(0,0,0,0,0,cw(1), 0,1,3,1,'h2222));
        tv.push_back(mk(0,0,0,0,0,cw(2,1,'hA5,'h10),
                        0,1,3,0,'h2222));
        tv.push_back(mk(0,0,0,0,0,cw(2,1,'h3C,'h20),
                        0,1,3,1,'h3333,1,'hA5));
        tv.push_back(mk(0,0,0,0,0,cw(2,0,0,'h10),
                        0,1,3,1,'h3333,1,'h3C));
        tv.push_back(mk(0,0,0,0,0,cw(2,0,0,'h20),
                        0,1,3,1,'h3333,1,'hA5));
        tv.push_back(mk(0,0,0,0,0,cw(2,0,0,'h10),
                        0,1,3,1,'h3333,1,'h3C));
        tv.push_back(mk(0,0,0,0,0,cw('h7001),
                        0,1,3,0,'h3333,1,'hA5));
        tv.push_back(mk(0,0,0,0,0,cw('h7001), 0,1,3,1,'h2222));
        tv.push_back(mk(0,1,0,0,0,cw(1), 0,1,3,1,'h2222));
        tv.push_back(mk(0,0,0,0,0,cw(1,1,'h77,'h10),
                        1,0,0,0,0));
        tv.push_back(mk(0,0,1,'h4444,1,cw(0,0,0,'h10),
                        1,0,0,0,0,1,'hA5));
        tv.push_back(mk(0,0,0,0,0,cw(0), 0,1,1,0,'h4444));
        tv.push_back(mk(0,0,0,0,0,cw(0), 0,1,1,1,'h4444));
        tv.push_back(mk(0,1,0,0,0,cw(0), 0,1,1,1,'h4444));
        tv.push_back(mk(0,1,1,'h5555,1,cw(0), 1,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,cw(0), 1,0,0,0,0));
        tv.push_back(mk(0,0,1,'h6666,1,cw(0), 1,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,cw(0), 0,1,1,0,'h6666));
        tv.push_back(mk(0,1,0,0,0,cw(0), 0,1,1,1,'h6666));
        tv.push_back(mk(0,0,1,'hAAAA,0,cw(0), 1,0,0,0,0));
        tv.push_back(mk(0,0,1,'hBBBB,0,cw(0), 1,0,1,0,0));
        tv.push_back(mk(1,0,1,'hDDDD,0,cw(0),
                        0,0,0,0,0,1,0));
        tv.push_back(mk(0,0,1,'hEEEE,0,cw(0), 0,0,0,0,0));
        tv.push_back(mk(0,1,0,0,0,cw(0), 0,0,0,0,0));
        tv.push_back(mk(0,0,1,'hCCCC,1,cw(1), 1,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,cw(1), 0,1,1,0,'hBBBB));
        tv.push_back(mk(0,0,0,0,0,cw(2), 0,1,1,0,'hBBBB));
        tv.push_back(mk(0,0,0,0,0,cw(2), 0,1,1,1,'h3333));
        tv.push_back(mk(0,0,0,0,0,cw(0), 0,1,1,0,'h3333));
        tv.push_back(mk(0,0,0,0,0,cw(0), 0,1,1,1,'hCCCC));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.prog_ready", 32'(bus.prog_ready), 0);
        chk("rst.loaded", 32'(bus.loaded), 0);
        chk("rst.prog_count", 32'(bus.prog_count), 0);
        chk("rst.csr_in", 32'(bus.csr_in), 0);
        chk("rst.data_reg_a", bus.data_reg_a, 0);
        chk("rst.data_reg_b", bus.data_reg_b, 0);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            arst_n         = !tv[i].rst;
            bus.load_start = tv[i].ld;
            bus.prog_valid = tv[i].pv;
            bus.prog_data  = tv[i].pd;
            bus.prog_last  = tv[i].pl;
            bus.data_reg_c = tv[i].c;
            @(negedge clk);
            chk($sformatf("v%0d.prog_ready", i),
                32'(bus.prog_ready), 32'(tv[i].rdy));
            chk($sformatf("v%0d.loaded", i),
                32'(bus.loaded), 32'(tv[i].lo));
            chk($sformatf("v%0d.prog_count", i),
                32'(bus.prog_count), 32'(tv[i].cnt));
            chk($sformatf("v%0d.csr_in", i),
                32'(bus.csr_in), 32'(tv[i].fr) << 4);
            chk($sformatf("v%0d.data_reg_b", i),
                bus.data_reg_b, {16'b0, tv[i].b});
            if (tv[i].ca)
                chk($sformatf("v%0d.data_reg_a", i),
                    bus.data_reg_a, {24'b0, tv[i].a});
        end

        // small flash: six offered words, only four fit
        @(posedge clk); #1;
        bus.load_start = 0; bus.prog_valid = 0;
        bus.data_reg_c = '0;
        bus2.load_start = 1;
        @(posedge clk); #1;
        bus2.load_start = 0;
        for (int i = 0; i < 6; i++) begin
            bus2.prog_valid = 1;
            bus2.prog_data  = 16'(16'h0100 + i);
            @(negedge clk);
            chk($sformatf("fa2.w%0d.prog_ready", i),
                32'(bus2.prog_ready), (i < 4) ? 1 : 0);
            chk($sformatf("fa2.w%0d.loaded", i),
                32'(bus2.loaded), (i < 4) ? 0 : 1);
            chk($sformatf("fa2.w%0d.prog_count", i),
                32'(bus2.prog_count), (i < 4) ? i : 4);
            @(posedge clk); #1;
        end
        bus2.prog_valid = 0;

        foreach (tv[0].c[k]) if (k < 5) begin
            int pcv;
            pcv = (k == 4) ? 5 : k;
            bus2.data_reg_c = cw(pcv);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("fa2.pc%0d.csr_in", pcv),
                32'(bus2.csr_in), 32'h10);
            chk($sformatf("fa2.pc%0d.data_reg_b", pcv),
                bus2.data_reg_b, 32'h100 + (pcv % 4));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
